// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART TX frame sequencer driving the output mux select, serial data and parity bit
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [1:0]            mux_sel,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic                  busy
);
  localparam int CW = $clog2(DATA_WIDTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t                state;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  par_en_q;
  assign ser_data = shift_reg[0];
  // Frame sequencer; mux_sel and busy are registered alongside the state they decode
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      shift_reg <= '0;
      par_en_q  <= 1'b0;
      par_bit   <= 1'b0;
      mux_sel   <= 2'b01;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (Data_Valid) begin
          shift_reg <= P_DATA;
          par_en_q  <= PAR_EN;
          par_bit   <= ^P_DATA ^ PAR_TYP;
          state     <= START;
          mux_sel   <= 2'b00;
          busy      <= 1'b1;
        end
        START: begin
          state   <= DATA;
          cnt     <= '0;
          mux_sel <= 2'b10;
        end
        DATA: begin
          shift_reg <= shift_reg >> 1;
          if (cnt == CW'(DATA_WIDTH - 1)) begin
            state   <= par_en_q ? PARITY : STOP;
            mux_sel <= par_en_q ? 2'b11 : 2'b01;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARITY: begin
          state   <= STOP;
          mux_sel <= 2'b01;
        end
        STOP: begin
          state   <= IDLE;
          mux_sel <= 2'b01;
          busy    <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          mux_sel <= 2'b01;
          busy    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: table-driven and randomized frame checks against a frame-list reference model
module tb_uart_tx_ctrl;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] P_DATA = '0;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [1:0] mux_sel;
  logic       ser_data;
  logic       par_bit;
  logic       busy;
  int errors = 0;
  int checks = 0;

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .mux_sel(mux_sel), .ser_data(ser_data), .par_bit(par_bit), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       pt;
    logic       exp_par;
    int         exp_busy;
  } vec_t;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one frame from IDLE and checks every line cycle plus the trailing IDLE cycle.
  // hold keeps Data_Valid high throughout; noise scribbles on the inputs mid-frame.
  task automatic run_frame(input logic [7:0] d, input logic pe, input logic pt,
                           input bit hold, input bit noise, output int busy_cnt);
    logic [1:0] ms_q[$];
    logic       sd_q[$];
    logic       ep;
    ep = (($countones(d) % 2) == 1) ^ pt;
    ms_q.push_back(2'b00); sd_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      ms_q.push_back(2'b10);
      sd_q.push_back(((d >> i) & 8'd1) != 0);
    end
    if (pe) begin ms_q.push_back(2'b11); sd_q.push_back(1'b0); end
    ms_q.push_back(2'b01); sd_q.push_back(1'b0);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Data_Valid = 1'b1;
    busy_cnt = 0;
    for (int k = 0; k < ms_q.size(); k++) begin
      @(negedge CLK);
      chk($sformatf("mux_sel[%0d]", k), {6'd0, mux_sel}, {6'd0, ms_q[k]});
      chk($sformatf("busy[%0d]", k), {7'd0, busy}, 8'd1);
      chk($sformatf("par_bit[%0d]", k), {7'd0, par_bit}, {7'd0, ep});
      if (ms_q[k] == 2'b10) chk($sformatf("ser_data[%0d]", k), {7'd0, ser_data}, {7'd0, sd_q[k]});
      busy_cnt += int'(busy);
      if (!hold) Data_Valid = (noise && k < ms_q.size() - 1) ? 1'(k % 2) : 1'b0;
      if (noise) begin P_DATA = 8'hFF; PAR_EN = ~PAR_EN; PAR_TYP = ~PAR_TYP; end
    end
    @(negedge CLK);
    chk("idle mux_sel", {6'd0, mux_sel}, 8'h01);
    chk("idle busy", {7'd0, busy}, 8'd0);
    chk("idle par_bit", {7'd0, par_bit}, {7'd0, ep});
    busy_cnt += int'(busy);
  endtask

  initial begin
    vec_t vecs[6];
    int   bc;
    logic [7:0] rd;
    logic rpe, rpt;
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 11};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b1, 11};
    vecs[2] = '{8'h01, 1'b0, 1'b0, 1'b1, 10};
    vecs[3] = '{8'h3C, 1'b1, 1'b0, 1'b0, 11};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b1, 11};
    vecs[5] = '{8'h80, 1'b0, 1'b1, 1'b0, 10};

    // Reset, then idle
    RST = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      chk("rst mux_sel", {6'd0, mux_sel}, 8'h01);
      chk("rst busy", {7'd0, busy}, 8'd0);
    end
    RST = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      chk("idle0 mux_sel", {6'd0, mux_sel}, 8'h01);
      chk("idle0 busy", {7'd0, busy}, 8'd0);
      chk("idle0 par_bit", {7'd0, par_bit}, 8'd0);
      chk("idle0 ser_data", {7'd0, ser_data}, 8'd0);
    end

    // Directed frames
    foreach (vecs[v]) begin
      run_frame(vecs[v].d, vecs[v].pe, vecs[v].pt, 1'b0, 1'b0, bc);
      chk($sformatf("vec%0d busy cycles", v), 8'(bc), 8'(vecs[v].exp_busy));
      chk($sformatf("vec%0d par_bit", v), {7'd0, par_bit}, {7'd0, vecs[v].exp_par});
    end

    // Inputs ignored while busy
    run_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, bc);
    chk("noise busy cycles", 8'(bc), 8'd11);
    repeat (3) begin
      @(negedge CLK);
      chk("noise no restart", {7'd0, busy}, 8'd0);
      chk("noise par held", {7'd0, par_bit}, 8'd0);
    end

    // Back-to-back with Data_Valid held
    run_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0, bc);
    run_frame(8'hAA, 1'b1, 1'b1, 1'b0, 1'b0, bc);
    chk("b2b second busy cycles", 8'(bc), 8'd11);

    // Reset mid-frame during the 4th DATA cycle
    P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b1; Data_Valid = 1'b1;
    @(negedge CLK);
    chk("mid start", {6'd0, mux_sel}, 8'h00);
    Data_Valid = 1'b0;
    repeat (4) @(negedge CLK);
    chk("mid data4", {6'd0, mux_sel}, 8'h02);
    RST = 1'b1;
    @(negedge CLK);
    chk("mid rst mux_sel", {6'd0, mux_sel}, 8'h01);
    chk("mid rst busy", {7'd0, busy}, 8'd0);
    chk("mid rst par_bit", {7'd0, par_bit}, 8'd0);
    RST = 1'b0;
    @(negedge CLK);
    chk("mid no resume", {7'd0, busy}, 8'd0);
    run_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, bc);
    chk("post rst busy cycles", 8'(bc), 8'd11);

    // Randomized frames
    repeat (25) begin
      rd = 8'($urandom); rpe = 1'($urandom); rpt = 1'($urandom);
      run_frame(rd, rpe, rpt, 1'b0, 1'($urandom_range(0, 3) == 0), bc);
      chk("rand busy cycles", 8'(bc), 8'(10 + int'(rpe)));
      if ($urandom_range(0, 1) == 1) @(negedge CLK);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Control and datapath stage directly upstream of the UART TX output mux.
- Accepts a parallel byte on a valid strobe and latches it with its parity configuration.
- Sequences the frame START -> DATA (LSB first) -> optional PARITY -> STOP.
- Drives the mux select, serial data bit and parity bit that the output mux registers onto the line; CLK is the TX bit-rate clock, one frame bit per cycle.

Parameters:
DATA_WIDTH, 8, payload bits per frame (>=2)

Ports:
CLK  input  1  TX bit clock; single clock domain
RST  input  1  synchronous, active-high reset
P_DATA  input  DATA_WIDTH  parallel payload
Data_Valid  input  1  payload request; sampled only in IDLE
PAR_EN  input  1  1 = append parity bit; sampled with payload
PAR_TYP  input  1  0 = even, 1 = odd; sampled with payload
mux_sel  output  2  00 start, 01 stop/idle, 10 serial data, 11 parity
ser_data  output  1  current payload bit (valid when mux_sel=10)
par_bit  output  1  parity of latched payload
busy  output  1  frame in progress

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (RST=1 at a CLK edge):
  - Outputs: state=IDLE, mux_sel=01, ser_data=0, par_bit=0, busy=0.
  - Internals: bit counter=0, shift register=0, latched PAR_EN=0.
  - RST overrides all other inputs, including mid-frame; the frame is abandoned and no resume occurs.
- States: IDLE, START, DATA, PARITY, STOP; each non-IDLE state except DATA lasts exactly one cycle.
- IDLE:
  - mux_sel=01, busy=0.
  - If Data_Valid=1 at the edge: latch P_DATA into shift register, latch PAR_EN/PAR_TYP, compute par_bit, go to START.
- START: mux_sel=00, busy=1; next state DATA, counter=0.
- DATA:
  - mux_sel=10, busy=1, ser_data=shift_reg[0].
  - Each cycle: shift right, counter+1.
  - Duration is DATA_WIDTH cycles. On the last bit (counter=DATA_WIDTH-1), go to PARITY if latched PAR_EN=1, else STOP.
- PARITY: mux_sel=11, busy=1; next state STOP.
- STOP: mux_sel=01, busy=1; next state IDLE unconditionally.
- Output timing:
  - mux_sel and busy are decoded from the state register (Moore, no input-to-output combinational path).
  - ser_data is the shift register LSB.
  - Line bits appear on TX_OUT one cycle later through the registered mux.
- Parity:
  - Even: par_bit = XOR of latched payload. Odd: par_bit = XNOR of latched payload.
  - par_bit is registered at accept and held stable until the next accept.
- Busy and frame length:
  - busy cycles per frame = DATA_WIDTH+2, or DATA_WIDTH+3 with parity.
  - Data_Valid, P_DATA, PAR_EN and PAR_TYP are ignored while busy=1; input changes mid-frame do not affect the frame.
- Back-to-back: at least one IDLE cycle separates frames. With Data_Valid held high, the next frame's START follows exactly one IDLE cycle after STOP.
- Counter width is clog2(DATA_WIDTH). The counter must not wrap inside DATA; it resets on entering START.

Test Plan:
- Reset, then idle:
  - Stimulus: RST high 2 cycles, then low, Data_Valid=0 for 5 cycles.
  - Required: mux_sel=01, busy=0, par_bit=0 throughout.
- Even-parity frame:
  - Stimulus: P_DATA=8'hA5, PAR_EN=1, PAR_TYP=0, 1-cycle Data_Valid.
  - Required mux_sel: 00; then 10 x8 with ser_data 1,0,1,0,0,1,0,1; then 11 with par_bit=0; then 01.
  - Required busy: high 11 cycles.
- Odd parity, and no parity:
  - Stimulus A: P_DATA=8'hA5, PAR_TYP=1. Required: par_bit=1.
  - Stimulus B: P_DATA=8'h01, PAR_EN=0. Required: no mux_sel=11 cycle, busy high 10 cycles, ser_data 1 then 0 x7.
- Inputs ignored while busy:
  - Stimulus: during a frame for 8'h3C, pulse Data_Valid with P_DATA=8'hFF and toggle PAR_EN/PAR_TYP.
  - Required: frame bits still 0,0,1,1,1,1,0,0 with original parity; no second frame starts.
- Back-to-back:
  - Stimulus: Data_Valid held high, P_DATA=8'h55 then 8'hAA.
  - Required: STOP, then exactly one IDLE cycle (mux_sel=01, busy=0), then START of the second frame.
- Reset mid-frame:
  - Stimulus: assert RST during the 4th DATA cycle.
  - Required: next cycle mux_sel=01, busy=0, par_bit=0. After release, a new Data_Valid produces a complete, correct frame.
